// File: rtl/ones_frame_scheduler.sv
// ones_frame_scheduler: round-robin arbiter that feeds one requester's frame
// at a time, LSB first, through a shared "two or more 1s" detector.
// Optional build macro: EARLY_DONE_EN makes a frame end on the edge that
// sees its second 1, instead of always consuming FRAME_LEN bits.
module ones_frame_scheduler #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*FRAME_LEN-1:0] frame_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      ser_bit,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic                      det
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(FRAME_LEN);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [IDW-1:0]       last_gnt;
    logic [IDW-1:0]       cur_idx;
    logic [IDW-1:0]       win_idx;
    logic [FRAME_LEN-1:0] shift_reg;
    logic [1:0]           ones_cnt;
    logic [1:0]           ones_nxt;
    logic [CW-1:0]        bit_idx;
    logic                 last_bit;
    logic                 finish;

    assign busy    = (state == SHIFT);
    assign ser_bit = busy & shift_reg[0];

    // Round-robin pick: first requester found starting one past the last winner
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        win_idx = last_gnt;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_gnt) + k) % NREQ;
            if (!found && req[idx]) begin
                win_idx = IDW'(idx);
                found   = 1'b1;
            end
        end
    end

    // Saturating count including the bit consumed this edge, and frame-end test
    always_comb begin
        ones_nxt = (ones_cnt == 2'd2) ? 2'd2 : ones_cnt + {1'b0, shift_reg[0]};
        last_bit = (bit_idx == CW'(FRAME_LEN - 1));
`ifdef EARLY_DONE_EN
        finish   = last_bit || (ones_nxt == 2'd2);
`else
        finish   = last_bit;
`endif
    end

    // Grant / shift state machine with registered result outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= IDW'(NREQ - 1);
            cur_idx   <= '0;
            shift_reg <= '0;
            ones_cnt  <= '0;
            bit_idx   <= '0;
            gnt       <= '0;
            done      <= 1'b0;
            done_id   <= '0;
            det       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        cur_idx   <= win_idx;
                        shift_reg <= frame_data[win_idx*FRAME_LEN +: FRAME_LEN];
                        ones_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    ones_cnt  <= ones_nxt;
                    bit_idx   <= bit_idx + 1'b1;
                    if (finish) begin
                        done     <= 1'b1;
                        done_id  <= cur_idx;
                        det      <= (ones_nxt == 2'd2);
                        gnt      <= '0;
                        last_gnt <= cur_idx;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ones_frame_scheduler.sv
// Bench for ones_frame_scheduler: directed scenarios with literal checks plus
// a per-cycle comparison against a frame-level reference model.
module tb_ones_frame_scheduler;
    localparam int NREQ = 4;
    localparam int FL   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [NREQ*FL-1:0] frame_data;
    logic [NREQ-1:0]  gnt;
    logic             busy, ser_bit, done, det;
    logic [1:0]       done_id;

    int asserts = 0;
    int fails   = 0;
    bit chk_on  = 1'b0;

    ones_frame_scheduler #(.NREQ(NREQ), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset), .req(req), .frame_data(frame_data),
        .gnt(gnt), .busy(busy), .ser_bit(ser_bit), .done(done),
        .done_id(done_id), .det(det)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of shift edges a frame takes: the position just after its second
    // 1 when early termination is built in, otherwise the full length.
    function automatic int frame_len(input logic [FL-1:0] f);
        int c = 0;
`ifdef EARLY_DONE_EN
        for (int i = 0; i < FL; i++) begin
            if (f[i]) c++;
            if (c == 2) return i + 1;
        end
`endif
        return FL + c - c;
    endfunction

    // Reference model: tracks which frame is in flight and how far along it is
    bit             m_busy;
    int             m_win, m_last, m_step, m_len;
    logic [FL-1:0]  m_frame;
    bit             m_done, m_det;
    int             m_did;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 0; m_win = 0; m_last = NREQ - 1; m_step = 0; m_len = 0;
            m_frame = '0; m_done = 0; m_det = 0; m_did = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_step++;
                if (m_step == m_len) begin
                    m_busy = 0; m_done = 1; m_did = m_win; m_last = m_win;
                    m_det  = ($countones(m_frame) >= 2);
                end
            end else if (|req) begin
                for (int k = NREQ; k >= 1; k--)
                    if (req[(m_last + k) % NREQ]) m_win = (m_last + k) % NREQ;
                m_busy  = 1;
                m_frame = frame_data[m_win*FL +: FL];
                m_step  = 0;
                m_len   = frame_len(m_frame);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_gnt",     32'(gnt),     m_busy ? 32'(1 << m_win) : 32'd0);
            chk("m_busy",    32'(busy),    32'(m_busy));
            chk("m_ser_bit", 32'(ser_bit), m_busy ? 32'(m_frame[m_step]) : 32'd0);
            chk("m_done",    32'(done),    32'(m_done));
            chk("m_done_id", 32'(done_id), 32'(m_did));
            chk("m_det",     32'(det),     32'(m_det));
        end
    end

    // Advance to the next negedge at which done is high; n counts negedges
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) chk("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    int n;
    int exp_len2;
    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b0; req = '0; frame_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_det", 32'(det), 32'd0);
        reset = 1'b1;

        // Requester 2, frame with two low 1s
`ifdef EARLY_DONE_EN
        exp_len2 = 2;
`else
        exp_len2 = 8;
`endif
        frame_data[2*FL +: FL] = 8'b0000_0011;
        req = 4'b0100;
        @(negedge clk);
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_busy", 32'(busy), 32'd1);
        req = '0;
        wait_done(n);
        chk("t2_latency", 32'(n), 32'(exp_len2));
        chk("t2_done_id", 32'(done_id), 32'd2);
        chk("t2_det", 32'(det), 32'd1);

        // Requester 1, single 1 -> full length, det=0
        frame_data[1*FL +: FL] = 8'b0001_0000;
        req = 4'b0010;
        @(negedge clk);
        chk("t3_gnt", 32'(gnt), 32'h2);
        req = '0;
        wait_done(n);
        chk("t3_latency", 32'(n), 32'd8);
        chk("t3_done_id", 32'(done_id), 32'd1);
        chk("t3_det", 32'(det), 32'd0);

        // All requesting continuously: strict rotation, 9-cycle spacing
        do_reset(1);
        for (int i = 0; i < NREQ; i++) frame_data[i*FL +: FL] = 8'b1000_0001;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_done(n);
            chk("t4_spacing", 32'(n), 32'd9);
            chk("t4_done_id", 32'(done_id), 32'(order[j]));
            chk("t4_det", 32'(det), 32'd1);
        end

        // Requester 3 holds; requester 0 joins mid-frame and wins next
        do_reset(1);
        req = 4'b1000;
        @(negedge clk);
        chk("t5_gnt3", 32'(gnt), 32'h8);
        repeat (3) @(negedge clk);
        req = 4'b1001;
        wait_done(n);
        chk("t5_first_id", 32'(done_id), 32'd3);
        @(negedge clk);
        chk("t5_gnt0", 32'(gnt), 32'h1);
        wait_done(n);
        chk("t5_second_id", 32'(done_id), 32'd0);
        wait_done(n);
        chk("t5_third_id", 32'(done_id), 32'd3);

        // Reset two edges long after 3 shift edges aborts the frame
        do_reset(1);
        req = 4'b1000;
        @(negedge clk);
        repeat (3) @(negedge clk);
        req = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_det", 32'(det), 32'd0);
        chk("t6_done_id", 32'(done_id), 32'd0);
        reset = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        chk("t6_gnt0", 32'(gnt), 32'h1);
        chk("t6_no_done", 32'(done), 32'd0);
        req = '0;
        wait_done(n);
        chk("t6_latency", 32'(n), 32'd8);
        chk("t6_done_id0", 32'(done_id), 32'd0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
